ts_stream_tx: RTL and testbench

//  Transmit-side TS framer: turns an upstream packet stream into a constant-rate 188-byte
//  TS byte stream with guaranteed 0x47 sync alignment, so a downstream sync finder locks after 5 packets.

---
 rtl/ts_pkg.sv | 22 ++
 rtl/ts_null_pkt_rom.sv | 23 ++
 rtl/ts_stream_tx.sv | 128 ++++++++++++
 tb/tb_ts_stream_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_pkg.sv
// Shared constants, state encoding and helpers for the TS transmit framer.
package ts_pkg;

    localparam int unsigned TS_PKT_LEN = 188;
    localparam logic [7:0]  TS_SYNC    = 8'h47;
    localparam logic [7:0]  TS_FILL    = 8'hFF;

    // Null-packet header bytes 2..4 (PID 0x1FFF, payload-only, CC 0); [2] is byte 2.
    localparam logic [2:0][7:0] TS_NULL_HDR = {8'h1F, 8'hFF, 8'h10};

    // FSM encoding kept as plain constants so legacy code can compare raw values.
    typedef logic [1:0] ts_state_t;
    localparam ts_state_t ST_IDLE = 2'd0;
    localparam ts_state_t ST_DATA = 2'd1;
    localparam ts_state_t ST_NULL = 2'd2;

    // Saturating increment for the 16-bit statistics counters.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/ts_null_pkt_rom.sv
// Combinational lookup: packet byte index -> byte of a TS null packet.
module ts_null_pkt_rom
    import ts_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = TS_SYNC,
    parameter logic [7:0] FILL_BYTE = TS_FILL
) (
    input  logic [7:0] byte_index,
    output logic [7:0] null_byte
);

    // Sync, 3-byte null header, then fill for the rest of the packet.
    always_comb begin
        case (byte_index)
            8'd1:    null_byte = SYNC_BYTE;
            8'd2:    null_byte = TS_NULL_HDR[2];
            8'd3:    null_byte = TS_NULL_HDR[1];
            8'd4:    null_byte = TS_NULL_HDR[0];
            default: null_byte = FILL_BYTE;
        endcase
    end

endmodule

// File: rtl/ts_stream_tx.sv
// Transmit-side TS framer: constant-rate, sync-aligned 188-byte packet stream
// with null-packet insertion at boundaries and fill padding on underflow.
module ts_stream_tx
    import ts_pkg::*;
#(
    parameter int unsigned PKT_LEN   = TS_PKT_LEN,
    parameter logic [7:0]  SYNC_BYTE = TS_SYNC,
    parameter logic [7:0]  FILL_BYTE = TS_FILL
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        BYTE_EN,
    input  logic [7:0]  IN_DATA,
    input  logic        IN_VALID,
    input  logic        IN_PSYNC,
    output logic        IN_READY,
    output logic [7:0]  DATA_OUT,
    output logic        DVALID_OUT,
    output logic        PSYNC_OUT,
    output logic [7:0]  BYTE_INDEX,
    output logic        UNDERFLOW,
    output logic        DROP,
    output logic [15:0] NULL_CNT,
    output logic [15:0] UFLOW_CNT
);

    localparam logic [7:0] LAST_IDX = 8'(PKT_LEN);

    ts_state_t  state;
    logic       pkt_uflow;
    logic [7:0] next_index;
    logic [7:0] null_byte;
    logic       boundary;
    logic       in_psync_valid;
    logic       in_payload;

    assign next_index     = BYTE_INDEX + 8'd1;
    assign boundary       = BYTE_EN && ((state == ST_IDLE) || (BYTE_INDEX == LAST_IDX));
    assign in_psync_valid = IN_VALID && IN_PSYNC;
    assign in_payload     = IN_VALID && !IN_PSYNC;

    ts_null_pkt_rom #(
        .SYNC_BYTE (SYNC_BYTE),
        .FILL_BYTE (FILL_BYTE)
    ) u_null_rom (
        .byte_index (next_index),
        .null_byte  (null_byte)
    );

    // Upstream handshake: open at every enabled boundary, and inside a DATA
    // packet except when a new packet start must be held for the next boundary.
    always_comb begin
        // NOTE: default first so every path assigns IN_READY and no latch is inferred.
        IN_READY = 1'b0;
        if (RST && BYTE_EN) begin
            if (boundary) begin
                IN_READY = ENABLE;
            end else if (state == ST_DATA) begin
                IN_READY = !in_psync_valid;
            end
        end
    end

    // Framing FSM, byte counter, output register and statistics counters.
    // NOTE: RST is asynchronous; a reset mid-packet abandons the packet outright.
    always_ff @(posedge DCLK or negedge RST) begin
        if (!RST) begin
            state      <= ST_IDLE;
            pkt_uflow  <= 1'b0;
            DATA_OUT   <= 8'h00;
            DVALID_OUT <= 1'b0;
            PSYNC_OUT  <= 1'b0;
            BYTE_INDEX <= 8'd0;
            UNDERFLOW  <= 1'b0;
            DROP       <= 1'b0;
            NULL_CNT   <= 16'd0;
            UFLOW_CNT  <= 16'd0;
        end else begin
            // NOTE: non-blocking throughout; these pulse defaults are overridden below.
            DVALID_OUT <= 1'b0;
            PSYNC_OUT  <= 1'b0;
            UNDERFLOW  <= 1'b0;
            DROP       <= 1'b0;
            if (boundary) begin
                pkt_uflow <= 1'b0;
                if (!ENABLE) begin
                    state      <= ST_IDLE;
                    BYTE_INDEX <= 8'd0;
                end else begin
                    BYTE_INDEX <= 8'd1;
                    DATA_OUT   <= SYNC_BYTE;
                    DVALID_OUT <= 1'b1;
                    PSYNC_OUT  <= 1'b1;
                    if (in_psync_valid) begin
                        state <= ST_DATA;
                    end else begin
                        state    <= ST_NULL;
                        NULL_CNT <= sat_inc16(NULL_CNT);
                        DROP     <= IN_VALID;
                    end
                end
            end else if (BYTE_EN) begin
                BYTE_INDEX <= next_index;
                DVALID_OUT <= 1'b1;
                if (state == ST_DATA) begin
                    if (in_payload) begin
                        DATA_OUT <= IN_DATA;
                    end else begin
                        DATA_OUT  <= FILL_BYTE;
                        UNDERFLOW <= 1'b1;
                    end
                    if (next_index == LAST_IDX) begin
                        if (pkt_uflow || !in_payload) begin
                            UFLOW_CNT <= sat_inc16(UFLOW_CNT);
                        end
                        pkt_uflow <= 1'b0;
                    end else if (!in_payload) begin
                        pkt_uflow <= 1'b1;
                    end
                end else begin
                    DATA_OUT <= null_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_ts_stream_tx.sv
// Self-checking bench for ts_stream_tx: a behavioural model pushes the expected
// output of every cycle into a scoreboard queue, popped one cycle later.
module tb_ts_stream_tx;

    logic        DCLK = 1'b0;
    logic        RST = 1'b0;
    logic        ENABLE = 1'b0;
    logic        BYTE_EN = 1'b0;
    logic [7:0]  IN_DATA = 8'h00;
    logic        IN_VALID = 1'b0;
    logic        IN_PSYNC = 1'b0;
    logic        IN_READY;
    logic [7:0]  DATA_OUT;
    logic        DVALID_OUT;
    logic        PSYNC_OUT;
    logic [7:0]  BYTE_INDEX;
    logic        UNDERFLOW;
    logic        DROP;
    logic [15:0] NULL_CNT;
    logic [15:0] UFLOW_CNT;

    always #5 DCLK = ~DCLK;

    ts_stream_tx dut (
        .DCLK       (DCLK),
        .RST        (RST),
        .ENABLE     (ENABLE),
        .BYTE_EN    (BYTE_EN),
        .IN_DATA    (IN_DATA),
        .IN_VALID   (IN_VALID),
        .IN_PSYNC   (IN_PSYNC),
        .IN_READY   (IN_READY),
        .DATA_OUT   (DATA_OUT),
        .DVALID_OUT (DVALID_OUT),
        .PSYNC_OUT  (PSYNC_OUT),
        .BYTE_INDEX (BYTE_INDEX),
        .UNDERFLOW  (UNDERFLOW),
        .DROP       (DROP),
        .NULL_CNT   (NULL_CNT),
        .UFLOW_CNT  (UFLOW_CNT)
    );

    typedef struct {
        logic       ps;
        logic [7:0] d;
    } src_t;

    typedef struct {
        logic        dv;
        logic        ps;
        logic        uf;
        logic        dr;
        logic [7:0]  data;
        logic [7:0]  idx;
        logic [15:0] nc;
        logic [15:0] uc;
    } exp_t;

    src_t src_q[$];
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Model state: 0 idle, 1 data packet, 2 null packet.
    int         m_state;
    int         m_idx;
    logic       m_flag;
    logic [7:0] m_data;
    int         m_null;
    int         m_uflow;

    logic en_r = 1'b0;
    int   gap_lo = 0;
    int   gap_hi = -1;
    int   n_dv = 0, n_uf = 0, n_drop = 0;
    int   sync_cnt = 0, sync_good = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_state  = 0;
        m_idx    = 0;
        m_flag   = 1'b0;
        m_data   = 8'h00;
        m_null   = 0;
        m_uflow  = 0;
        sync_cnt = 0;
        sync_good = 0;
        exp_q.delete();
    endtask

    task automatic push_packet(input int len, input logic [7:0] first, input int seed);
        src_t s;
        for (int i = 0; i < len; i++) begin
            s.ps = (i == 0);
            s.d  = (i == 0) ? first : 8'(seed * 16 + i * 3);
            src_q.push_back(s);
        end
    endtask

    // Drive one cycle, predict its outcome, then compare after the clock edge.
    task automatic step(input logic be);
        exp_t       e;
        logic       v, ps, rdy, gap;
        logic [7:0] d;
        gap = (m_state == 1) && (m_idx != 188) && (m_idx + 1 >= gap_lo) && (m_idx + 1 <= gap_hi);
        v   = (src_q.size() > 0) && !gap;
        ps  = v ? src_q[0].ps : 1'b0;
        d   = v ? src_q[0].d : 8'hEE;
        ENABLE = en_r; BYTE_EN = be; IN_VALID = v; IN_PSYNC = ps; IN_DATA = d;

        e.dv = 1'b0; e.ps = 1'b0; e.uf = 1'b0; e.dr = 1'b0; rdy = 1'b0;
        if (be) begin
            if (m_state == 0 || m_idx == 188) begin
                m_flag = 1'b0;
                if (!en_r) begin
                    m_state = 0;
                    m_idx   = 0;
                end else begin
                    rdy = 1'b1; e.dv = 1'b1; e.ps = 1'b1;
                    m_data = 8'h47; m_idx = 1;
                    if (v && ps) m_state = 1;
                    else begin
                        m_state = 2;
                        if (m_null < 65535) m_null++;
                        e.dr = v;
                    end
                end
            end else begin
                m_idx++;
                e.dv = 1'b1;
                if (m_state == 1) begin
                    if (v && !ps) begin
                        m_data = d; rdy = 1'b1;
                    end else begin
                        m_data = 8'hFF; e.uf = 1'b1; m_flag = 1'b1; rdy = !(v && ps);
                    end
                    if (m_idx == 188 && m_flag && m_uflow < 65535) m_uflow++;
                end else begin
                    case (m_idx)
                        2: m_data = 8'h1F;
                        3: m_data = 8'hFF;
                        4: m_data = 8'h10;
                        default: m_data = 8'hFF;
                    endcase
                end
            end
        end
        e.data = m_data; e.idx = 8'(m_idx); e.nc = 16'(m_null); e.uc = 16'(m_uflow);
        exp_q.push_back(e);

        #1;
        check("in_ready", IN_READY, rdy);
        if (rdy && v) void'(src_q.pop_front());

        @(posedge DCLK);
        #1;
        e = exp_q.pop_front();
        check("dvalid", DVALID_OUT, e.dv);
        check("psync", PSYNC_OUT, e.ps);
        check("underflow", UNDERFLOW, e.uf);
        check("drop", DROP, e.dr);
        check("byte_index", BYTE_INDEX, e.idx);
        check("data_out", DATA_OUT, e.data);
        check("null_cnt", NULL_CNT, e.nc);
        check("uflow_cnt", UFLOW_CNT, e.uc);

        if (DVALID_OUT) begin
            n_dv++;
            if (PSYNC_OUT && DATA_OUT == 8'h47) begin
                if (sync_cnt == 188) sync_good++;
                else sync_good = 1;
                sync_cnt = 1;
            end else begin
                sync_cnt++;
            end
        end
        if (UNDERFLOW) n_uf++;
        if (DROP) n_drop++;
    endtask

    initial begin
        int  base_dv, base_uf, base_drop;
        bit  done;

        // Reset state.
        reset_model();
        repeat (3) @(posedge DCLK);
        #1;
        check("rst_dvalid", DVALID_OUT, 1'b0);
        check("rst_index", BYTE_INDEX, 8'd0);
        check("rst_data", DATA_OUT, 8'd0);
        check("rst_null_cnt", NULL_CNT, 16'd0);
        check("rst_uflow_cnt", UFLOW_CNT, 16'd0);
        RST = 1'b1;

        // Three back-to-back data packets, first upstream byte 0x00.
        en_r = 1'b1;
        for (int p = 0; p < 3; p++) push_packet(188, 8'h00, p + 1);
        repeat (3 * 188) step(1'b1);
        check("t2_dvalid_count", n_dv, 564);
        check("t2_null_cnt", NULL_CNT, 16'd0);
        check("t2_no_drop", n_drop, 0);

        // No input: two null packets.
        repeat (2 * 188) step(1'b1);
        check("t3_null_cnt", NULL_CNT, 16'd2);
        check("t3_sync_lock", sync_good >= 5, 1'b1);

        // Underflow gap at indices 100..109.
        base_uf = n_uf;
        gap_lo = 100; gap_hi = 109;
        push_packet(178, 8'h12, 5);
        repeat (188) step(1'b1);
        gap_lo = 0; gap_hi = -1;
        check("t4_underflow_pulses", n_uf - base_uf, 10);
        check("t4_uflow_cnt", UFLOW_CNT, 16'd1);
        check("t4_src_drained", src_q.size(), 0);

        // Misalignment: five stray bytes ahead of a packet start.
        base_drop = n_drop;
        for (int i = 0; i < 5; i++) begin
            src_t s;
            s.ps = 1'b0; s.d = 8'(8'hC0 + i);
            src_q.push_back(s);
        end
        push_packet(188, 8'h33, 6);
        repeat (6 * 188) step(1'b1);
        check("t5_drops", n_drop - base_drop, 5);
        check("t5_null_cnt", NULL_CNT, 16'd7);
        check("t5_src_drained", src_q.size(), 0);

        // Reduced strobe rate, ENABLE dropped at index 50 of the second packet.
        base_dv = n_dv;
        push_packet(188, 8'h44, 7);
        push_packet(188, 8'h55, 8);
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (m_state == 1 && m_idx == 50 && src_q.size() < 188) en_r = 1'b0;
            step((c % 3) == 0);
            if (!en_r && m_state == 0) done = 1'b1;
        end
        check("t6_idle_reached", done, 1'b1);
        check("t6_dvalid_count", n_dv - base_dv, 376);
        repeat (6) step(1'b1);
        check("t6_idle_index", BYTE_INDEX, 8'd0);

        // Reset mid-packet with BYTE_EN held high.
        en_r = 1'b1;
        push_packet(188, 8'hA5, 9);
        repeat (60) step(1'b1);
        ENABLE = 1'b1; BYTE_EN = 1'b1; IN_VALID = 1'b1; IN_PSYNC = 1'b0;
        RST = 1'b0;
        #1;
        check("mid_rst_dvalid", DVALID_OUT, 1'b0);
        check("mid_rst_index", BYTE_INDEX, 8'd0);
        check("mid_rst_data", DATA_OUT, 8'd0);
        check("mid_rst_in_ready", IN_READY, 1'b0);
        check("mid_rst_null_cnt", NULL_CNT, 16'd0);
        check("mid_rst_uflow_cnt", UFLOW_CNT, 16'd0);
        reset_model();
        src_q.delete();
        @(posedge DCLK);
        #1;
        check("mid_rst_hold_index", BYTE_INDEX, 8'd0);
        RST = 1'b1;
        push_packet(188, 8'h5A, 10);
        step(1'b1);
        check("post_rst_first_index", BYTE_INDEX, 8'd1);
        repeat (20) step(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
